// File: rtl/grant_burst_ctrl.sv
// Burst controller behind a 4-way arbiter: latches the one-hot granted owner, moves
// BURST_LEN beats from its data port over a valid/ready bus, then pulses its done line.
module grant_burst_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic              gnt_2,
  input  logic              gnt_3,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic [DATA_W-1:0] data_3,
  input  logic              bus_ready,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic [1:0]        owner,
  output logic              busy,
  output logic              done_0,
  output logic              done_1,
  output logic              done_2,
  output logic              done_3,
  output logic              abort,
  output logic              gnt_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOCK = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        owner_q, owner_d;

  logic [3:0]        gnt_s;
  logic              gnt_one_hot_s;
  logic              gnt_multi_s;
  logic [1:0]        gnt_idx_s;
  logic              owner_gnt_s;
  logic              last_beat_s;
  logic [3:0]        done_s;
  logic              valid_s;
  logic              busy_s;
  logic              abort_s;
  logic              err_s;

  // Index of a one-hot grant vector; only meaningful when the vector is one-hot.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Grant decoding shared by the FSM.
  always_comb begin
    gnt_s         = {gnt_3, gnt_2, gnt_1, gnt_0};
    gnt_one_hot_s = (gnt_s != 4'd0) && ((gnt_s & (gnt_s - 4'd1)) == 4'd0);
    gnt_multi_s   = (gnt_s != 4'd0) && !gnt_one_hot_s;
    gnt_idx_s     = onehot_idx(gnt_s);
    owner_gnt_s   = gnt_s[owner_q];
    last_beat_s   = (cnt_q == LAST_CNT);
  end

  // Next-state, counter, owner and combinational bus/status outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    valid_s = 1'b0;
    busy_s  = 1'b0;
    abort_s = 1'b0;
    err_s   = 1'b0;
    done_s  = 4'd0;
    case (state_q)
      S_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (gnt_one_hot_s) begin
          owner_d = gnt_idx_s;
          state_d = S_LOCK;
        end else if (gnt_multi_s) begin
          err_s = reset;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCK: begin
        busy_s = 1'b1;
        cnt_d  = {CNT_W{1'b0}};
        if (!owner_gnt_s) begin
          abort_s = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        busy_s = 1'b1;
        // Withdrawn grant wins over a beat that would otherwise complete the burst.
        if (!owner_gnt_s) begin
          abort_s = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_IDLE;
        end else begin
          valid_s = 1'b1;
          if (bus_ready && last_beat_s) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_DONE;
          end else if (bus_ready) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      S_DONE: begin
        busy_s          = 1'b1;
        cnt_d           = {CNT_W{1'b0}};
        done_s[owner_q] = 1'b1;
        state_d         = S_IDLE;
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_IDLE;
      end
    endcase
  end

  // Data mux from the latched owner.
  always_comb begin
    case (owner_q)
      2'd0:    bus_data = data_0;
      2'd1:    bus_data = data_1;
      2'd2:    bus_data = data_2;
      2'd3:    bus_data = data_3;
      default: bus_data = data_0;
    endcase
  end

  // State, beat counter and owner registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      owner_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  assign bus_valid = valid_s;
  assign busy      = busy_s;
  assign abort     = abort_s;
  assign gnt_err   = err_s;
  assign owner     = owner_q;
  assign done_0    = done_s[0];
  assign done_1    = done_s[1];
  assign done_2    = done_s[2];
  assign done_3    = done_s[3];

endmodule

// File: tb/tb_grant_burst_ctrl.sv
// Self-checking bench for grant_burst_ctrl: directed test-plan steps plus a random
// phase, every cycle compared against a burst-level reference model.
module tb_grant_burst_ctrl;
  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        gnt;
  logic [DATA_W-1:0] data [4];
  logic              bus_ready;

  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic [1:0]        owner;
  logic              busy;
  logic              done_0, done_1, done_2, done_3;
  logic              abort;
  logic              gnt_err;
  logic [3:0]        done_v;

  always #5 clk = ~clk;
  assign done_v = {done_3, done_2, done_1, done_0};

  grant_burst_ctrl #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .gnt_0(gnt[0]), .gnt_1(gnt[1]), .gnt_2(gnt[2]), .gnt_3(gnt[3]),
    .data_0(data[0]), .data_1(data[1]), .data_2(data[2]), .data_3(data[3]),
    .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_data(bus_data),
    .owner(owner), .busy(busy),
    .done_0(done_0), .done_1(done_1), .done_2(done_2), .done_3(done_3),
    .abort(abort), .gnt_err(gnt_err)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: a burst is either in its setup cycle, moving beats, or finishing.
  bit m_busy, m_setup, m_finish;
  int m_beats, m_owner;

  // Events observed on the DUT outputs.
  int dut_done [4];
  int dut_xfer, dut_abort, dut_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_setup = 0; m_finish = 0; m_beats = 0; m_owner = 0;
  endtask

  task automatic check_outputs();
    logic e_valid, e_busy, e_abort, e_err;
    logic [3:0] e_done;
    int e_owner;
    e_valid = 0; e_busy = 0; e_abort = 0; e_err = 0; e_done = 4'd0;
    e_owner = m_owner;
    if (!reset) begin
      e_owner = 0;
    end else if (!m_busy) begin
      e_err = ($countones(gnt) > 1);
    end else begin
      e_busy = 1;
      if (m_finish) e_done[m_owner] = 1'b1;
      else if (!gnt[m_owner]) e_abort = 1;
      else if (!m_setup) e_valid = 1;
    end
    chk("bus_valid", {31'd0, bus_valid}, {31'd0, e_valid});
    chk("busy",      {31'd0, busy},      {31'd0, e_busy});
    chk("abort",     {31'd0, abort},     {31'd0, e_abort});
    chk("gnt_err",   {31'd0, gnt_err},   {31'd0, e_err});
    chk("done",      {28'd0, done_v},    {28'd0, e_done});
    chk("owner",     {30'd0, owner},     e_owner);
    chk("bus_data",  {24'd0, bus_data},  {24'd0, data[e_owner]});
    if (reset) begin
      for (int i = 0; i < 4; i++) dut_done[i] += int'(done_v[i]);
      dut_xfer  += int'(bus_valid && bus_ready);
      dut_abort += int'(abort);
      dut_err   += int'(gnt_err);
    end
  endtask

  task automatic model_advance();
    if (!reset) return;
    if (!m_busy) begin
      if ($countones(gnt) == 1) begin
        for (int i = 0; i < 4; i++) if (gnt[i]) m_owner = i;
        m_busy = 1; m_setup = 1; m_beats = 0;
      end
    end else if (m_finish) begin
      m_busy = 0; m_finish = 0;
    end else if (!gnt[m_owner]) begin
      m_busy = 0; m_setup = 0;
    end else if (m_setup) begin
      m_setup = 0;
    end else if (bus_ready) begin
      m_beats++;
      if (m_beats == BURST_LEN) m_finish = 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset(input int n);
    gnt = 4'd0;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    run(n);
    reset = 1'b1;
  endtask

  int d0, d1, d2, d3, x0, a0, e0;

  initial begin
    reset = 1'b1; gnt = 4'd0; bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) data[i] = 8'(i * 17 + 3);
    for (int i = 0; i < 4; i++) dut_done[i] = 0;
    dut_xfer = 0; dut_abort = 0; dut_err = 0;
    #2;

    // Reset then idle.
    apply_reset(3);
    run(10);

    // Single burst for requester 1.
    data[1] = 8'hA5; bus_ready = 1'b1;
    d1 = dut_done[1]; x0 = dut_xfer;
    gnt = 4'b0010; run(7);
    gnt = 4'b0000; run(3);
    chk("single_done1", dut_done[1] - d1, 1);
    chk("single_beats", dut_xfer - x0, BURST_LEN);

    // Backpressure on requester 2.
    d2 = dut_done[2]; x0 = dut_xfer;
    gnt = 4'b0100; bus_ready = 1'b1; run(2);
    begin
      logic [6:0] rdy_pat;
      rdy_pat = 7'b1011001;
      for (int i = 0; i < 7; i++) begin
        bus_ready = rdy_pat[i];
        cycle();
      end
    end
    bus_ready = 1'b1; run(1);
    gnt = 4'b0000; run(3);
    chk("bp_done2", dut_done[2] - d2, 1);
    chk("bp_beats", dut_xfer - x0, BURST_LEN);

    // Sequential owners 0..3.
    d0 = dut_done[0]; d1 = dut_done[1]; d2 = dut_done[2]; d3 = dut_done[3];
    for (int i = 0; i < 4; i++) begin
      gnt = 4'(1 << i); run(10);
    end
    gnt = 4'b0000; run(3);
    chk("seq_done0", dut_done[0] - d0, 1);
    chk("seq_done1", dut_done[1] - d1, 1);
    chk("seq_done2", dut_done[2] - d2, 1);
    chk("seq_done3", dut_done[3] - d3, 1);

    // Illegal multi-hot grant, then a legal one.
    e0 = dut_err; d3 = dut_done[3];
    gnt = 4'b1001; run(4);
    chk("illegal_err_count", dut_err - e0, 4);
    gnt = 4'b1000; run(7);
    gnt = 4'b0000; run(2);
    chk("illegal_done3", dut_done[3] - d3, 1);

    // Grant withdrawn after two beats.
    a0 = dut_abort; d1 = dut_done[1]; x0 = dut_xfer;
    gnt = 4'b0010; run(4);
    gnt = 4'b0000; run(4);
    chk("abort_count", dut_abort - a0, 1);
    chk("abort_no_done1", dut_done[1] - d1, 0);
    chk("abort_beats", dut_xfer - x0, 2);

    // Asynchronous reset in the middle of XFER.
    gnt = 4'b0001; run(3);
    apply_reset(2);
    run(3);

    // Randomised traffic.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       gnt = 4'd0;
          1:       gnt = 4'($urandom_range(0, 15));
          default: gnt = 4'(1 << $urandom_range(0, 3));
        endcase
      end
      bus_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
      if ($urandom_range(0, 199) == 0) apply_reset(1);
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/grant_burst_ctrl.md
Name: grant_burst_ctrl

Overview:
- Downstream consumer of the 4-way request/grant arbiter: takes one-hot grants gnt_0..gnt_3 and runs a fixed-length burst on a shared bus on behalf of the granted requester.
- Latches the owner, moves BURST_LEN beats from that requester's data port under a valid/ready handshake, then pulses that requester's done line so it can drop its request.
- Flags illegal (non-one-hot) grants and aborts cleanly if the owner's grant is withdrawn mid-burst.

Parameters:
- DATA_W, 8, width of each requester data port and of bus_data.
- BURST_LEN, 4, beats per burst; legal range 1..255.
- CNT_W, 8, beat counter width; must hold BURST_LEN.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- gnt_0 / gnt_1 / gnt_2 / gnt_3  input  1 each  grants from the arbiter; one-hot or all-zero is legal.
- data_0 / data_1 / data_2 / data_3  input  DATA_W each  per-requester source data.
- bus_ready  input  1  sink accepts the current beat.
- bus_valid  output  1  beat present on bus_data.
- bus_data  output  DATA_W  data_<owner>, muxed combinationally from the latched owner.
- owner  output  2  index of the current burst owner.
- busy  output  1  high in LOCK, XFER and DONE.
- done_0 / done_1 / done_2 / done_3  output  1 each  one-cycle pulse at burst completion.
- abort  output  1  one-cycle pulse when a burst is cut short.
- gnt_err  output  1  one-cycle pulse on a multi-hot grant.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, beat counter=0, owner=0.
  - All outputs 0.
  - bus_data=data_0, since owner=0 selects it.
- States: IDLE, LOCK, XFER, DONE (registered state, combinational outputs).
- IDLE:
  - Exactly one gnt_i=1: owner<=i, counter<=0, go LOCK.
  - Two or more gnt high: gnt_err=1 for that cycle, stay IDLE, owner unchanged.
  - All zero: stay IDLE.
- LOCK: one-cycle setup with bus_valid=0, then go XFER. First beat is offered 2 cycles after the grant edge.
- XFER:
  - bus_valid=1.
  - A beat transfers on a rising edge with bus_valid=1 and bus_ready=1; counter increments on each transfer.
  - When the transferring beat is beat BURST_LEN (counter==BURST_LEN-1), go DONE.
  - bus_ready=0 holds bus_valid and bus_data stable (stall of any length).
- DONE:
  - done_<owner>=1 for exactly one cycle, bus_valid=0, busy=1.
  - Next state IDLE, where a new grant may be accepted the following cycle.
- Abort: if gnt_<owner> is 0 in LOCK or XFER:
  - abort=1 that cycle and bus_valid=0 combinationally.
  - Any beat presented in that cycle does not count.
  - Next state IDLE; no done pulse.
  - Beats already transferred are not retracted.
- While busy, grants for non-owners are ignored and gnt_err is not evaluated.
- Abort has priority over completion in the same cycle.
- Counter never wraps: it is held at 0 outside XFER.
- BURST_LEN=1: XFER lasts for exactly one accepted beat.
- Async reset mid-burst: immediate return to reset values; no done or abort pulse is generated.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release, all gnt=0 for 10 cycles -> all outputs stay 0, bus_data=data_0.
- Single burst: gnt_1=1 held, data_1=8'hA5, bus_ready=1:
  - bus_valid high on cycles 2..5 after the grant edge, owner=1.
  - done_1 pulses one cycle on cycle 6; busy low after.
- Backpressure: gnt_2=1, bus_ready toggles 1,0,0,1,1,0,1 -> exactly 4 transfers counted, bus_data stable during stalls, done_2 after the 4th accepted beat.
- Sequential owners: gnt_0, gnt_1, gnt_2, gnt_3 each held 10 cycles in turn, ready=1 -> four bursts with owner 0,1,2,3 and done_0..done_3 each pulsing once, in order.
- Illegal grant: gnt_0=gnt_3=1 in IDLE -> gnt_err pulses each such cycle, busy stays 0; then gnt_3 alone -> normal burst with owner=3.
- Abort and reset: gnt_1 dropped after 2 beats -> abort pulse, no done_1, IDLE next. Separately, reset asserted mid-XFER -> bus_valid=0 immediately, state IDLE.
